// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if
// Bundles the command/response handshake and the APB3 bus of apb_cmd_master.
//   master modport : the initiator's view (apb_cmd_master itself)
//   slave modport  : the environment's view (command source + APB slave)
// Handshake rules:
//   cmd_valid/cmd_ready : a command transfers on a rising edge where both are
//                         high; cmd_valid may be held while cmd_ready is low.
//   rsp_valid           : one-cycle pulse per accepted command, no backpressure.
//   APB                 : psel/penable SETUP->ACCESS; prdata/pslverr are only
//                         meaningful in an ACCESS cycle with pready high.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
               paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// APB3 initiator: turns single-beat register commands into APB transfers,
// holds address/data through wait states, returns read data and error status,
// and aborts transfers whose pready stays low for TIMEOUT ACCESS cycles
// (TIMEOUT = 0 disables the abort).
// Ports:
//   apb_clk     : clock, rising edge
//   preset_n    : synchronous active-low reset
//   bus         : apb_cmd_master_if.master (command, response, APB signals)
//   o_dbg_state : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
module apb_cmd_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    apb_clk,
    input  logic                    preset_n,
    apb_cmd_master_if.master        bus,
    output logic [1:0]              o_dbg_state
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_inc;
    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_complete;
    logic              w_timeout;

    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    always_ff @(posedge apb_clk) begin
        if (!preset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        // Saturating increment so the counter can never wrap back to zero.
        w_wait_inc   = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                w_cmd_ready = preset_n;
                if (bus.cmd_valid && preset_n) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                // Completion wins over timeout when pready rises on the last
                // allowed cycle; ready here lets the next command go straight
                // into SETUP without an idle cycle.
                if (bus.pready) begin
                    w_complete   = 1'b1;
                    w_cmd_ready  = preset_n;
                    w_next_state = (bus.cmd_valid && preset_n) ? SETUP : IDLE;
                end else if ((TIMEOUT != 0) && (w_wait_inc == CNT_LIMIT)) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_accept = bus.cmd_valid && w_cmd_ready;
    end

    always_ff @(posedge apb_clk) begin
        if (!preset_n) begin
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            // Bus address/data only move on accept, so they stay stable
            // through SETUP, every wait state, and the idle time afterwards.
            if (w_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
            end
            if (w_next_state == SETUP) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ACCESS) && !bus.pready) begin
                r_wait_cnt <= w_wait_inc;
            end
            r_rsp_valid <= w_complete || w_timeout;
            if (w_complete) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                r_rsp_err     <= bus.pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.psel        = (r_state != IDLE);
    assign bus.penable     = (r_state == ACCESS);
    assign bus.busy        = (r_state != IDLE);
    assign bus.paddr       = r_paddr;
    assign bus.pwrite      = r_pwrite;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
// Self-checking bench for apb_cmd_master. Inputs change 1 ns after the rising
// edge and outputs are sampled there too. Expected responses
// {rsp_timeout, rsp_err, rsp_rdata} are pushed to exp_q when a command is
// driven and popped when rsp_valid is observed.
module tb_apb_cmd_master;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int RW      = DATA_W + 2;

    logic       apb_clk = 1'b0;
    logic       preset_n = 1'b0;
    logic [1:0] dbg_state;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .apb_clk     (apb_clk),
        .preset_n    (preset_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 apb_clk = ~apb_clk;

    int n_vec = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];

    // driver tasks
    task automatic tick();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
    endtask

    // One command from IDLE with a scripted slave: 'waits' ACCESS cycles with
    // pready low, then pready high. Garbage on prdata/pslverr while not ready.
    task automatic run_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input int waits, input logic [7:0] rd, input logic se,
                            output logic [RW-1:0] got, output int lat);
        logic to;
        to = (TIMEOUT != 0) && (waits >= TIMEOUT);
        if (to) exp_q.push_back({1'b1, 1'b1, 8'h00});
        else    exp_q.push_back({1'b0, se, (w ? 8'h00 : rd)});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'($urandom_range(0, 255));
        bus.cmd_wdata = 8'($urandom_range(0, 255));
        lat = 0;
        got = '0;
        for (int k = 0; k < 60; k++) begin
            if (bus.rsp_valid) break;
            bus.pready  = (k == waits + 1);
            bus.prdata  = bus.pready ? rd : 8'($urandom_range(0, 255));
            bus.pslverr = bus.pready ? se : 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        if (bus.rsp_valid) got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        preset_n = 1'b0;
        bus.cmd_valid = 1'b1;
        tick();
        tick();
        n_vec++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.busy, bus.pwrite} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0000000", {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.busy, bus.pwrite}); end
        n_vec++; if (bus.paddr !== 8'h00) begin n_err++; $display("FAIL reset_paddr: got %h expected 00", bus.paddr); end
        n_vec++; if (bus.pwdata !== 8'h00) begin n_err++; $display("FAIL reset_pwdata: got %h expected 00", bus.pwdata); end
        n_vec++; if (bus.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h expected 00", bus.rsp_rdata); end
        n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        bus.cmd_valid = 1'b0;
        preset_n = 1'b1;
        tick();
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", bus.cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h04;
        bus.cmd_wdata = 8'hA5;
        bus.prdata    = 8'hFF;
        #1;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_cmd_ready: got %b expected 1", bus.cmd_ready); end
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'hFF;
        bus.cmd_wdata = 8'h00;
        n_vec++; if ({bus.psel, bus.penable} !== 2'b10) begin n_err++; $display("FAIL wr_setup: got %b expected 10", {bus.psel, bus.penable}); end
        n_vec++; if ({bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 8'h04, 8'hA5}) begin
            n_err++; $display("FAIL wr_setup_fields: got %b/%h/%h expected 1/04/a5", bus.pwrite, bus.paddr, bus.pwdata); end
        bus.pready = 1'b1;
        tick();
        n_vec++; if ({bus.psel, bus.penable, bus.pwdata} !== {2'b11, 8'hA5}) begin
            n_err++; $display("FAIL wr_access: got %b%b/%h expected 11/a5", bus.psel, bus.penable, bus.pwdata); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_early_rsp: got %b expected 0", bus.rsp_valid); end
        tick();
        bus.pready = 1'b0;
        n_vec++; if ({bus.rsp_valid, bus.psel} !== 2'b10) begin n_err++; $display("FAIL wr_latency: got rsp_valid/psel %b expected 10", {bus.rsp_valid, bus.psel}); end
        got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL wr_rsp: got %h expected %h", got, exp); end
        tick();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_read_wait3();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h08;
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'h99;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if ({bus.psel, bus.penable, bus.paddr, bus.rsp_valid} !== {1'b1, (k > 0), 8'h08, 1'b0}) begin
                n_err++; $display("FAIL rd_cycle%0d: got psel %b penable %b paddr %h rsp %b expected 1 %b 08 0", k, bus.psel, bus.penable, bus.paddr, bus.rsp_valid, (k > 0)); end
            bus.pready  = (k == 4);
            bus.prdata  = (k == 4) ? 8'h3C : 8'($urandom_range(0, 255));
            bus.pslverr = (k == 4) ? 1'b0 : 1'b1;
            tick();
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_latency: got rsp_valid %b expected 1 at 5 cycles", bus.rsp_valid); end
        got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL rd_rsp: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h01;
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        tick();
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h10;
        bus.cmd_wdata = 8'h00;
        bus.pready    = 1'b1;
        bus.prdata    = 8'h5A;
        #1;
        n_vec++; if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b100) begin
            n_err++; $display("FAIL b2b_setup1: got psel/penable/ready %b expected 100", {bus.psel, bus.penable, bus.cmd_ready}); end
        tick();
        n_vec++; if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b111) begin
            n_err++; $display("FAIL b2b_access1: got psel/penable/ready %b expected 111", {bus.psel, bus.penable, bus.cmd_ready}); end
        exp_q.push_back({1'b0, 1'b0, 8'h5A});
        tick();
        bus.cmd_valid = 1'b0;
        n_vec++; if ({bus.rsp_valid, bus.psel, bus.penable, bus.pwrite, bus.paddr} !== {4'b1100, 8'h10}) begin
            n_err++; $display("FAIL b2b_setup2: got rsp/psel/penable/pwrite %b paddr %h expected 1100 10", {bus.rsp_valid, bus.psel, bus.penable, bus.pwrite}, bus.paddr); end
        got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_rsp1: got %h expected %h", got, exp); end
        tick();
        n_vec++; if ({bus.rsp_valid, bus.psel, bus.penable} !== 3'b011) begin
            n_err++; $display("FAIL b2b_access2: got rsp/psel/penable %b expected 011", {bus.rsp_valid, bus.psel, bus.penable}); end
        tick();
        bus.pready = 1'b0;
        n_vec++; if ({bus.rsp_valid, bus.psel} !== 2'b10) begin n_err++; $display("FAIL b2b_done2: got rsp/psel %b expected 10", {bus.rsp_valid, bus.psel}); end
        got = {bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata};
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL b2b_rsp2: got %h expected %h", got, exp); end
    endtask

    task automatic test_slverr();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        run_xfer(1'b1, 8'h20, 8'h77, 1, 8'hEE, 1'b1, got, lat);
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL slverr_rsp: got %h expected %h", got, exp); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL slverr_latency: got %0d expected 3", lat); end
        run_xfer(1'b0, 8'h21, 8'h00, 0, 8'hC3, 1'b0, got, lat);
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL after_err_rsp: got %h expected %h", got, exp); end
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL after_err_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_timeout();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        run_xfer(1'b0, 8'h30, 8'h00, TIMEOUT, 8'h11, 1'b0, got, lat);
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL timeout_rsp: got %h expected %h", got, exp); end
        n_vec++; if (lat !== TIMEOUT + 1) begin n_err++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 1); end
        n_vec++; if ({bus.psel, bus.busy} !== 2'b00) begin n_err++; $display("FAIL timeout_release: got psel/busy %b expected 00", {bus.psel, bus.busy}); end
        run_xfer(1'b0, 8'h31, 8'h00, TIMEOUT - 1, 8'h66, 1'b0, got, lat);
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL last_cycle_rsp: got %h expected %h", got, exp); end
        n_vec++; if (lat !== TIMEOUT + 1) begin n_err++; $display("FAIL last_cycle_latency: got %0d expected %0d", lat, TIMEOUT + 1); end
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h40;
        bus.cmd_wdata = 8'h5C;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        n_vec++; if ({bus.psel, bus.penable} !== 2'b11) begin n_err++; $display("FAIL mid_in_access: got %b expected 11", {bus.psel, bus.penable}); end
        preset_n = 1'b0;
        tick();
        bus.pready = 1'b1;
        bus.prdata = 8'hAB;
        n_vec++; if ({bus.psel, bus.penable, bus.pwrite, bus.busy, bus.rsp_valid, bus.cmd_ready} !== 6'b0) begin
            n_err++; $display("FAIL mid_release: got psel/penable/pwrite/busy/rsp/ready %b expected 000000", {bus.psel, bus.penable, bus.pwrite, bus.busy, bus.rsp_valid, bus.cmd_ready}); end
        n_vec++; if ({bus.paddr, bus.pwdata} !== 16'h0000) begin n_err++; $display("FAIL mid_fields: got %h/%h expected 00/00", bus.paddr, bus.pwdata); end
        preset_n = 1'b1;
        bus.pready = 1'b0;
        tick();
        n_vec++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_err++; $display("FAIL mid_after: got rsp/ready %b expected 01", {bus.rsp_valid, bus.cmd_ready}); end
        run_xfer(1'b0, 8'h41, 8'h00, 2, 8'h96, 1'b0, got, lat);
        exp = exp_q.pop_front();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL mid_recover_rsp: got %h expected %h", got, exp); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL mid_recover_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_random();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        int waits;
        int exp_lat;
        for (int i = 0; i < 12; i++) begin
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2) : $urandom_range(0, 5);
            exp_lat = (waits >= TIMEOUT) ? TIMEOUT + 1 : waits + 2;
            run_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     waits, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), got, lat);
            exp = exp_q.pop_front();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL rand%0d_rsp: got %h expected %h (waits %0d)", i, got, exp, waits); end
            n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait3();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
